// File: rtl/rosc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rosc_pkg
// Description : Shared constants, width helpers and state encodings for the
//               ring-oscillator entropy collector.
// Revision    : 1.0 - initial release
// ============================================================================
package rosc_pkg;

  // Width of one delivered entropy word.
  localparam int ENTROPY_WORD_WIDTH = 32;

  // Default sampling divider and health-check run length.
  localparam int SAMPLE_DIV_DEFAULT  = 16;
  localparam int STUCK_LIMIT_DEFAULT = 64;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  // Counter widths for the default configuration.
  localparam int DIV_CTR_W_DEFAULT = clog2_min1(SAMPLE_DIV_DEFAULT);
  localparam int RUN_CTR_W_DEFAULT = clog2_min1(STUCK_LIMIT_DEFAULT);

  // Bit position counter inside the word being packed.
  localparam int BIT_CNT_W = $clog2(ENTROPY_WORD_WIDTH);

  // Von Neumann corrector: waiting for the first or the second bit of a pair.
  typedef enum logic [0:0] {
    VN_EMPTY = 1'b0,
    VN_HOLD  = 1'b1
  } vn_state_e;

endpackage : rosc_pkg
`default_nettype wire

// File: rtl/rosc_sync.sv
`default_nettype none
// ============================================================================
// Module      : rosc_sync
// Description : Two-flop synchroniser bringing one free-running oscillator
//               output into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module rosc_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous level, then let any metastability settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : rosc_sync
`default_nettype wire

// File: rtl/rosc_entropy_collector.sv
`default_nettype none
// ============================================================================
// Module      : rosc_entropy_collector
// Description : Samples and XOR-combines ring oscillator outputs, debiases
//               the raw stream with a von Neumann corrector, packs 32-bit
//               words, delivers them over valid/ack and monitors for a stuck
//               source.
// Revision    : 1.0 - initial release
// ============================================================================
module rosc_entropy_collector
  import rosc_pkg::*;
#(
  parameter int NUM_ROSC    = 2,
  parameter int SAMPLE_DIV  = SAMPLE_DIV_DEFAULT,
  parameter int STUCK_LIMIT = STUCK_LIMIT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_ROSC-1:0]           rosc_in,
  output logic [ENTROPY_WORD_WIDTH-1:0] entropy_data,
  output logic                          entropy_valid,
  input  logic                          entropy_ack,
  output logic                          stuck_error
);

  localparam int WW    = ENTROPY_WORD_WIDTH;
  localparam int DIV_W = clog2_min1(SAMPLE_DIV);
  localparam int RUN_W = clog2_min1(STUCK_LIMIT);

  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [RUN_W-1:0]     RUN_LAST = RUN_W'(STUCK_LIMIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(WW - 1);

  // --------------------------------------------------------------------------
  // Synchronisers and raw bit
  // --------------------------------------------------------------------------
  logic [NUM_ROSC-1:0] sync_bits;
  logic                raw;

  for (genvar g = 0; g < NUM_ROSC; g++) begin : g_sync
    rosc_sync u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (rosc_in[g]),
      .sync_o  (sync_bits[g])
    );
  end

  assign raw = ^sync_bits;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0]     div_ctr_q, div_ctr_d;
  vn_state_e            vn_state_q, vn_state_d;
  logic                 first_q, first_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]        shreg_q, shreg_d;
  logic                 pending_q, pending_d;
  logic [WW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 prev_q, prev_d;
  logic                 prev_valid_q, prev_valid_d;
  logic [RUN_W-1:0]     run_ctr_q, run_ctr_d;
  logic                 stuck_q, stuck_d;

  logic          tick;
  logic          emit;
  logic          word_done;
  logic [WW-1:0] shifted;
  logic          pending_live;

  // Sample tick generator: free-running divider while collection is enabled.
  always_comb begin
    tick      = enable && (div_ctr_q == DIV_LAST);
    div_ctr_d = div_ctr_q;
    if (!enable || tick) begin
      div_ctr_d = '0;
    end else begin
      div_ctr_d = div_ctr_q + 1'b1;
    end
  end

  // Von Neumann corrector: pair up raw samples, emit the first bit of an unequal pair.
  always_comb begin
    vn_state_d = vn_state_q;
    first_d    = first_q;
    emit       = 1'b0;
    if (!enable) begin
      vn_state_d = VN_EMPTY;
      first_d    = 1'b0;
    end else if (tick) begin
      case (vn_state_q)
        VN_EMPTY: begin
          first_d    = raw;
          vn_state_d = VN_HOLD;
        end
        VN_HOLD: begin
          vn_state_d = VN_EMPTY;
          emit       = (first_q != raw);
        end
        default: vn_state_d = VN_EMPTY;
      endcase
    end
  end

  // Packer: shift corrected bits in MSB-first order; frozen while a word waits.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    word_done = 1'b0;
    shifted   = {shreg_q[WW-2:0], first_q};
    if (!enable) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (emit && !pending_q) begin
      shreg_d = shifted;
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d = '0;
        word_done = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end
  end

  // Output handshake: direct load when the slot frees this cycle, else park the word in shreg.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    pending_d    = pending_q;
    pending_live = pending_q && enable;
    if (word_done) begin
      if (!valid_q || entropy_ack) begin
        data_d  = shifted;
        valid_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else if (entropy_ack && valid_q) begin
      if (pending_live) begin
        data_d    = shreg_q;
        pending_d = 1'b0;
      end else begin
        valid_d = 1'b0;
      end
    end
    if (!enable) begin
      pending_d = 1'b0;
    end
  end

  // Health check: count repeated raw samples and latch a stuck-source error.
  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    run_ctr_d    = run_ctr_q;
    stuck_d      = stuck_q;
    if (!enable) begin
      prev_d       = 1'b0;
      prev_valid_d = 1'b0;
      run_ctr_d    = '0;
      stuck_d      = 1'b0;
    end else if (tick) begin
      prev_d = raw;
      if (!prev_valid_q) begin
        prev_valid_d = 1'b1;
      end else begin
        if (raw == prev_q) begin
          if (run_ctr_q != RUN_LAST) begin
            run_ctr_d = run_ctr_q + 1'b1;
          end
        end else begin
          run_ctr_d = '0;
        end
        if (run_ctr_d == RUN_LAST) begin
          stuck_d = 1'b1;
        end
      end
    end
  end

  // Collection-side registers: divider, corrector and packer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_ctr_q  <= '0;
      vn_state_q <= VN_EMPTY;
      first_q    <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
    end else begin
      div_ctr_q  <= div_ctr_d;
      vn_state_q <= vn_state_d;
      first_q    <= first_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Delivery registers: output word, valid flag and parked-word flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
    end
  end

  // Health registers: previous sample, run length and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= 1'b0;
      prev_valid_q <= 1'b0;
      run_ctr_q    <= '0;
      stuck_q      <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      run_ctr_q    <= run_ctr_d;
      stuck_q      <= stuck_d;
    end
  end

  assign entropy_data  = data_q;
  assign entropy_valid = valid_q;
  assign stuck_error   = stuck_q;

endmodule : rosc_entropy_collector
`default_nettype wire
